fp_to_int: RTL and testbench
============================

Name: fp_to_int

Overview:
Multi-cycle converter from IEEE-754 binary64 to signed 64-bit two's-complement integer. It is the inverse direction of the integer→double path that feeds the fp_adder datapath, and turns adder sums back into fixed integers. Input and output use independent valid/ready handshakes. Alignment uses an iterative shifter that moves SHIFT_STEP bits per cycle.

Parameters:
SHIFT_STEP, 4, bits shifted per ALIGN cycle; legal values 1..16.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
in_valid  in  1  operand valid
in_ready  out  1  converter idle and able to accept an operand
a  in  64  binary64 operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result  out  64  signed integer result
invalid  out  1  NaN, Inf or out-of-range operand
inexact  out  1  fraction bits were discarded (rounding occurred)

Behaviour:
- One clock domain. Reset is asynchronous and active-low, on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, invalid=0, inexact=0.
- Asserting reset mid-operation aborts the conversion and returns to IDLE.
- Fields: s=a[63], e=a[62:52], f=a[51:0]. Let E=e-1023 and m={1,f}.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, register fields and classify, then go to ALIGN, or to ROUND if no shift is needed or the operand is special.
  - ALIGN: shift by min(SHIFT_STEP, remaining); remaining decrements by the same amount. When remaining reaches 0, go to ROUND.
  - ROUND: round, saturate, negate if s=1, register outputs, go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE.
- in_ready is 0 in every state except IDLE. No operand is accepted while busy.
- Shift direction and amount:
  - 0<=E<=51: right shift by 52-E. Track guard bit and sticky OR of every bit shifted out.
  - 52<=E<=62: left shift by E-52. The result is exact.
- Latency: with n=ceil(shamt/SHIFT_STEP), out_valid rises n+2 cycles after the accept edge. Special and tiny cases have n=0, so latency is 2.
- Rounding is round-to-nearest-even on the magnitude, before negation. inexact = guard|sticky.
- Special cases, none of which use ALIGN:
  - e=0x7FF with f!=0 (NaN): result=0x8000_0000_0000_0000, invalid=1.
  - e=0x7FF with f=0 (Inf): result=0x7FFF_FFFF_FFFF_FFFF if s=0, else 0x8000_0000_0000_0000; invalid=1.
  - E>=63: same saturated values and invalid=1. Exception: a=0xC3E0_0000_0000_0000 (-2^63 exactly) gives result 0x8000_0000_0000_0000 with invalid=0.
  - Zero (including -0.0): result=0, inexact=0.
  - E=-1 (0.5<=|x|<1): magnitude 1 if f!=0, else 0 (tie to even). inexact=1.
  - E<=-2 or e=0 (tiny or denormal, nonzero): result=0, inexact=1.
- invalid and inexact are never both 1.
- Holding out_ready low keeps result and flags unchanged.

Optional Feature:
FP2INT_RTZ_EN
- Defined: adds input port rtz (1 bit), sampled at accept. rtz=1 selects round-toward-zero (C cast semantics); rtz=0 selects RNE. inexact is computed the same way under both modes.
- Undefined: no rtz port; mode is always RNE.

Decomposition:
- Package fp2int_pkg: EXP_W=11, FRAC_W=52, BIAS=1023, INT_MAX and INT_MIN constants, state enum {IDLE, ALIGN, ROUND, DONE}, operand class enum {ZERO, TINY, NORMAL, INF, NAN}.
- One sub-module, fp64_unpack: combinational field split, class, E and shamt/direction computation.

Test Plan:
- a=0x3FF0_0000_0000_0000 (1.0), SHIFT_STEP=4 -> result=1, inexact=0, out_valid 15 cycles after accept (shamt=52, n=13).
- a=0x4004_0000_0000_0000 (2.5) -> result=2, inexact=1. a=0xC00C_0000_0000_0000 (-3.5) -> result=0xFFFF_FFFF_FFFF_FFFC (-4), inexact=1. With FP2INT_RTZ_EN and rtz=1, -3.5 -> 0xFFFF_FFFF_FFFF_FFFD.
- a=0x43E0_0000_0000_0000 (2^63) -> result=0x7FFF_FFFF_FFFF_FFFF, invalid=1. a=0xC3E0_0000_0000_0000 -> result=0x8000_0000_0000_0000, invalid=0. Both at latency 2.
- a=0x7FF8_0000_0000_0000 (NaN) -> result=0x8000_0000_0000_0000, invalid=1. a=0x3FE0_0000_0000_0000 (0.5) -> result=0, inexact=1.
- Backpressure: out_ready low for 5 cycles in DONE -> result stable, in_ready=0, a second in_valid is ignored. Then out_ready=1 -> IDLE next cycle.
- Reset mid-ALIGN: rst_n low -> out_valid=0, in_ready=1 immediately. A new conversion after release completes correctly.

Source files
------------

// File: rtl/fp2int_pkg.sv
// fp2int_pkg: shared constants, state/class enums and helpers for the
// binary64 -> signed 64-bit integer converter (fp_to_int).
//   EXP_W/FRAC_W/BIAS : binary64 field geometry
//   INT_MAX/INT_MIN   : saturation values of the signed 64-bit result
//   state_t           : converter FSM states
//   fp_class_t        : operand classification
//   unpack_t          : everything fp64_unpack derives from one operand
package fp2int_pkg;

    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int BIAS   = 1023;

    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        TINY   = 3'd1,
        NORMAL = 3'd2,
        INF    = 3'd3,
        NAN    = 3'd4
    } fp_class_t;

    typedef struct packed {
        logic              sign;
        fp_class_t         cls;
        logic              half;   // 0.5 <= |x| < 1
        logic              ovf;    // |x| >= 2^63
        logic              shl;    // 1: left shift, 0: right shift
        logic [6:0]        shamt;  // alignment distance in bits
        logic [FRAC_W:0]   mant;   // {1, f}
    } unpack_t;

    // Saturated result for an out-of-range magnitude of the given sign.
    function automatic logic [63:0] sat_value(input logic sign);
        logic [63:0] v;
        if (sign) begin
            v = INT_MIN;
        end else begin
            v = INT_MAX;
        end
        return v;
    endfunction

    // Two's-complement negate when sign is set.
    function automatic logic [63:0] apply_sign(input logic sign, input logic [63:0] mag);
        logic [63:0] v;
        if (sign) begin
            v = ~mag + 64'd1;
        end else begin
            v = mag;
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_to_int_if.sv
// fp_to_int_if: operand/result handshake bundle for fp_to_int.
//   in_valid/in_ready/a           : operand channel (master -> converter)
//   rtz                           : round-toward-zero select, only with FP2INT_RTZ_EN
//   out_valid/out_ready           : result channel (converter -> master)
//   result/invalid/inexact        : converted integer and exception flags
// modport master: the requester side; modport slave: the converter.
interface fp_to_int_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
`ifdef FP2INT_RTZ_EN
    logic        rtz;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        invalid;
    logic        inexact;

    modport master (
`ifdef FP2INT_RTZ_EN
        output rtz,
`endif
        output in_valid,
        output a,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  invalid,
        input  inexact
    );

    modport slave (
`ifdef FP2INT_RTZ_EN
        input  rtz,
`endif
        input  in_valid,
        input  a,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output invalid,
        output inexact
    );

endinterface

// File: rtl/fp64_unpack.sv
// fp64_unpack: combinational split of a binary64 operand into sign, class,
// mantissa and alignment (direction + distance) for fp_to_int.
//   a : binary64 operand
//   u : unpacked view (see fp2int_pkg::unpack_t)
module fp64_unpack
    import fp2int_pkg::*;
(
    input  logic [63:0] a,
    output unpack_t     u
);

    logic [EXP_W-1:0]  exp_s;
    logic [FRAC_W-1:0] frac_s;
    logic signed [12:0] e_unb_s;

    // Classify the operand and derive the shift needed to land the binary point at bit 0.
    always_comb begin
        exp_s   = a[62:52];
        frac_s  = a[51:0];
        e_unb_s = $signed({2'b00, exp_s}) - 13'sd1023;

        u.sign  = a[63];
        u.cls   = NORMAL;
        u.half  = 1'b0;
        u.ovf   = 1'b0;
        u.shl   = 1'b0;
        u.shamt = 7'd0;
        u.mant  = {1'b1, frac_s};

        if (exp_s == 11'h7FF) begin
            if (frac_s != 52'd0) begin
                u.cls = NAN;
            end else begin
                u.cls = INF;
            end
        end else if (exp_s == 11'd0) begin
            if (frac_s == 52'd0) begin
                u.cls = ZERO;
            end else begin
                u.cls = TINY;
            end
        end else if (e_unb_s < -13'sd1) begin
            u.cls = TINY;
        end else if (e_unb_s == -13'sd1) begin
            u.half = 1'b1;
        end else if (e_unb_s >= 13'sd63) begin
            u.ovf = 1'b1;
        end else if (e_unb_s <= 13'sd51) begin
            u.shamt = 7'(13'sd52 - e_unb_s);
        end else begin
            u.shl   = 1'b1;
            u.shamt = 7'(e_unb_s - 13'sd52);
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// fp_to_int: multi-cycle IEEE-754 binary64 -> signed 64-bit integer converter.
// Alignment is iterative, SHIFT_STEP bits per ALIGN cycle; rounding is
// round-to-nearest-even on the magnitude, then the sign is applied.
// Optional macro FP2INT_RTZ_EN adds bus.rtz (sampled at accept) selecting
// round-toward-zero instead of RNE.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp_to_int_if.slave (in_valid/in_ready/a[/rtz], out_valid/out_ready/
//           result/invalid/inexact)
module fp_to_int
    import fp2int_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_to_int_if.slave   bus
);

    unpack_t     u_s;

    state_t      state_r;
    logic [63:0] mag_r;
    logic        guard_r;
    logic        sticky_r;
    logic [6:0]  rem_r;
    logic        shl_r;
    logic        sign_r;
    logic        rtz_r;
    logic        special_r;
    logic [63:0] spec_res_r;
    logic        spec_inv_r;
    logic        spec_inx_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [63:0] result_r;
    logic        invalid_r;
    logic        inexact_r;

    logic        rtz_in_s;
    logic        spec_s;
    logic [63:0] spec_res_s;
    logic        spec_inv_s;
    logic        spec_inx_s;
    logic [63:0] half_mag_s;
    logic [6:0]  step_s;
    logic [63:0] out_mask_s;
    logic [63:0] mag_shift_s;
    logic        guard_nxt_s;
    logic        sticky_nxt_s;
    logic        round_up_s;
    logic [63:0] mag_rnd_s;

    fp64_unpack u_unpack (
        .a (bus.a),
        .u (u_s)
    );

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.invalid   = invalid_r;
    assign bus.inexact   = inexact_r;

`ifdef FP2INT_RTZ_EN
    assign rtz_in_s = bus.rtz;
`else
    assign rtz_in_s = 1'b0;
`endif

    // Results for operands that bypass alignment (NaN, Inf, overflow, zero, tiny, half).
    always_comb begin
        spec_s     = 1'b1;
        spec_res_s = 64'd0;
        spec_inv_s = 1'b0;
        spec_inx_s = 1'b0;
        half_mag_s = 64'd0;
        case (u_s.cls)
            NAN: begin
                spec_res_s = INT_MIN;
                spec_inv_s = 1'b1;
            end
            INF: begin
                spec_res_s = sat_value(u_s.sign);
                spec_inv_s = 1'b1;
            end
            ZERO: begin
                spec_res_s = 64'd0;
            end
            TINY: begin
                spec_res_s = 64'd0;
                spec_inx_s = 1'b1;
            end
            NORMAL: begin
                if (u_s.ovf) begin
                    // -2^63 is the one E=63 value that is representable.
                    if (bus.a == 64'hC3E0_0000_0000_0000) begin
                        spec_res_s = INT_MIN;
                    end else begin
                        spec_res_s = sat_value(u_s.sign);
                        spec_inv_s = 1'b1;
                    end
                end else if (u_s.half) begin
                    // Exactly 0.5 ties to even (0); anything above rounds to 1.
                    if (!rtz_in_s && (u_s.mant[51:0] != 52'd0)) begin
                        half_mag_s = 64'd1;
                    end else begin
                        half_mag_s = 64'd0;
                    end
                    spec_res_s = apply_sign(u_s.sign, half_mag_s);
                    spec_inx_s = 1'b1;
                end else begin
                    spec_s = 1'b0;
                end
            end
            default: begin
                spec_res_s = INT_MIN;
                spec_inv_s = 1'b1;
            end
        endcase
    end

    // One alignment step: shift by min(SHIFT_STEP, remaining), collecting guard/sticky on right shifts.
    always_comb begin
        if (rem_r < 7'(SHIFT_STEP)) begin
            step_s = rem_r;
        end else begin
            step_s = 7'(SHIFT_STEP);
        end
        out_mask_s = (64'd1 << step_s) - 64'd1;
        if (shl_r) begin
            mag_shift_s  = mag_r << step_s;
            guard_nxt_s  = guard_r;
            sticky_nxt_s = sticky_r;
        end else begin
            mag_shift_s  = mag_r >> step_s;
            // Highest bit leaving becomes the new guard; the old guard and the rest feed sticky.
            guard_nxt_s  = mag_r[6'(step_s - 7'd1)];
            sticky_nxt_s = sticky_r | guard_r | (|(mag_r & (out_mask_s >> 1)));
        end
    end

    // Round-to-nearest-even (or truncate under rtz) on the aligned magnitude.
    always_comb begin
        if (rtz_r) begin
            round_up_s = 1'b0;
        end else begin
            round_up_s = guard_r & (sticky_r | mag_r[0]);
        end
        mag_rnd_s = mag_r + {63'd0, round_up_s};
    end

    // Converter FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mag_r       <= 64'd0;
            guard_r     <= 1'b0;
            sticky_r    <= 1'b0;
            rem_r       <= 7'd0;
            shl_r       <= 1'b0;
            sign_r      <= 1'b0;
            rtz_r       <= 1'b0;
            special_r   <= 1'b0;
            spec_res_r  <= 64'd0;
            spec_inv_r  <= 1'b0;
            spec_inx_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= 64'd0;
            invalid_r   <= 1'b0;
            inexact_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        sign_r     <= u_s.sign;
                        mag_r      <= {11'd0, u_s.mant};
                        guard_r    <= 1'b0;
                        sticky_r   <= 1'b0;
                        rem_r      <= u_s.shamt;
                        shl_r      <= u_s.shl;
                        rtz_r      <= rtz_in_s;
                        special_r  <= spec_s;
                        spec_res_r <= spec_res_s;
                        spec_inv_r <= spec_inv_s;
                        spec_inx_r <= spec_inx_s;
                        in_ready_r <= 1'b0;
                        if (spec_s || (u_s.shamt == 7'd0)) begin
                            state_r <= ROUND;
                        end else begin
                            state_r <= ALIGN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ALIGN: begin
                    mag_r    <= mag_shift_s;
                    guard_r  <= guard_nxt_s;
                    sticky_r <= sticky_nxt_s;
                    rem_r    <= rem_r - step_s;
                    if (rem_r == step_s) begin
                        state_r <= ROUND;
                    end else begin
                        state_r <= ALIGN;
                    end
                end
                ROUND: begin
                    if (special_r) begin
                        result_r  <= spec_res_r;
                        invalid_r <= spec_inv_r;
                        inexact_r <= spec_inx_r;
                    end else begin
                        result_r  <= apply_sign(sign_r, mag_rnd_s);
                        invalid_r <= 1'b0;
                        inexact_r <= guard_r | sticky_r;
                    end
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: directed self-checking bench for fp_to_int (SHIFT_STEP=4).
// Latency is counted in cycles from the cycle in which the operand is
// accepted to the first cycle in which out_valid is high (n+2).
module tb_fp_to_int;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   lat;

    fp_to_int_if bus ();

    fp_to_int #(.SHIFT_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present one operand, wait (bounded) for out_valid; leaves the result in DONE.
    task automatic convert(input string tag, input logic [63:0] op, input logic rtz_i, output int cyc);
        bus.a        = op;
        bus.in_valid = 1'b1;
`ifdef FP2INT_RTZ_EN
        bus.rtz      = rtz_i;
`else
        if (rtz_i) $display("note: rtz request ignored in this build");
`endif
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [63:0] op, input logic rtz_i,
                           input logic [63:0] exp_res, input logic exp_inv,
                           input logic exp_inx, input int exp_lat);
        int c;
        convert(tag, op, rtz_i, c);
        check({tag, "_result"},  bus.result,        exp_res);
        check({tag, "_invalid"}, 64'(bus.invalid),  64'(exp_inv));
        check({tag, "_inexact"}, 64'(bus.inexact),  64'(exp_inx));
        check({tag, "_latency"}, 64'(c),            64'(exp_lat));
        release_result();
        check({tag, "_back_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 64'd0;
        bus.out_ready = 1'b0;
`ifdef FP2INT_RTZ_EN
        bus.rtz       = 1'b0;
`endif
        #12;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    bus.result,         64'd0);
        check("rst_invalid",   64'(bus.invalid),   64'd0);
        check("rst_inexact",   64'(bus.inexact),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //        tag        operand                 rtz   result                  inv   inx   lat
        run_vec("one",      64'h3FF0_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 15);
        run_vec("two_5",    64'h4004_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0002, 1'b0, 1'b1, 15);
        run_vec("m3_5",     64'hC00C_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 15);
        run_vec("one_5",    64'h3FF8_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0002, 1'b0, 1'b1, 15);
        run_vec("one_eps",  64'h3FF0_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 15);
        run_vec("two5_eps", 64'h4004_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0003, 1'b0, 1'b1, 15);
        run_vec("p2_63",    64'h43E0_0000_0000_0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2);
        run_vec("m2_63",    64'hC3E0_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 2);
        run_vec("m2_63_up", 64'hC3E0_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 2);
        run_vec("nan",      64'h7FF8_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 2);
        run_vec("pinf",     64'h7FF0_0000_0000_0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2);
        run_vec("minf",     64'hFFF0_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 2);
        run_vec("half",     64'h3FE0_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 2);
        run_vec("m0_75",    64'hBFE8_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 2);
        run_vec("zero",     64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 2);
        run_vec("mzero",    64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 2);
        run_vec("denorm",   64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 2);
        run_vec("tiny",     64'h3F00_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 2);
        run_vec("p2_52p1",  64'h4330_0000_0000_0001, 1'b0, 64'h0010_0000_0000_0001, 1'b0, 1'b0, 2);
        run_vec("m2_53p2",  64'hC340_0000_0000_0001, 1'b0, 64'hFFDF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 3);
        run_vec("p2_62",    64'h43D0_0000_0000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 5);
        run_vec("max_fin",  64'h43DF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FC00, 1'b0, 1'b0, 5);
`ifdef FP2INT_RTZ_EN
        run_vec("m3_5_rtz", 64'hC00C_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, 15);
        run_vec("m0_75_rtz",64'hBFE8_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 2);
`endif

        // Backpressure: result held while out_ready is low, new operands ignored.
        convert("bp", 64'h4004_0000_0000_0000, 1'b0, lat);
        bus.a        = 64'h7FF8_0000_0000_0000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_result",    bus.result,         64'h0000_0000_0000_0002);
            check("bp_inexact",   64'(bus.inexact),   64'd1);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        release_result();
        check("bp_rel_out_valid", 64'(bus.out_valid), 64'd0);
        check("bp_rel_in_ready",  64'(bus.in_ready),  64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_ghost", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of ALIGN aborts the conversion immediately.
        bus.a        = 64'h3FF0_0000_0000_0000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec("after_rst", 64'hC00C_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
